btn_conditioner: RTL and testbench

//   Front end for the hood's push-buttons (up/left/middle/right/down). Synchronises raw

---
 rtl/btn_conditioner.sv | 159 +++++++++++++++
 tb/tb_btn_conditioner.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// Push-button front end: 2-flop sync, per-channel debounce FSM, level plus press/release pulses.
// Define BTN_CONDITIONER_LONG_PRESS_EN to build the per-channel hold counter and btn_long pulse.

module btn_channel #(
    parameter int DEBOUNCE_CYC = 1000000,
`ifdef BTN_CONDITIONER_LONG_PRESS_EN
    parameter int LONG_CYC     = 300000000,
`endif
    parameter int CNT_W        = 29
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel,
    output logic lng
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        HELD,
        RELEASE_CHK
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [1:0]       sync_pipe;
    logic             s2;
    state_t           state;
    logic [CNT_W-1:0] dcnt;

    assign s2 = sync_pipe[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_pipe <= '0;
            state     <= IDLE;
            dcnt      <= '0;
            level     <= 1'b0;
            press     <= 1'b0;
            rel       <= 1'b0;
        end else begin
            sync_pipe <= {sync_pipe[0], raw};
            press     <= 1'b0;
            rel       <= 1'b0;
            case (state)
                IDLE: begin
                    if (s2) begin
                        state <= PRESS_CHK;
                        dcnt  <= '0;
                    end
                end
                PRESS_CHK: begin
                    if (!s2) begin
                        state <= IDLE;
                    end else if (dcnt == DB_LAST) begin
                        state <= HELD;
                        level <= 1'b1;
                        press <= 1'b1;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!s2) begin
                        state <= RELEASE_CHK;
                        dcnt  <= '0;
                    end
                end
                RELEASE_CHK: begin
                    // A high sample here is a bounce: back to HELD, hold time keeps running.
                    if (s2) begin
                        state <= HELD;
                    end else if (dcnt == DB_LAST) begin
                        state <= IDLE;
                        level <= 1'b0;
                        rel   <= 1'b1;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BTN_CONDITIONER_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] HC_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] HC_PRE  = CNT_W'(LONG_CYC - 2);

    logic [CNT_W-1:0] hcnt;
    logic             press_accept;
    logic             holding;

    assign press_accept = (state == PRESS_CHK) && s2 && (dcnt == DB_LAST);
    assign holding      = (state == HELD) || (state == RELEASE_CHK);

    // Saturating at HC_LAST is what limits btn_long to one pulse per hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcnt <= '0;
            lng  <= 1'b0;
        end else begin
            lng <= 1'b0;
            if (press_accept) begin
                hcnt <= '0;
            end else if (holding && (hcnt != HC_LAST)) begin
                hcnt <= hcnt + 1'b1;
                if (hcnt == HC_PRE) lng <= 1'b1;
            end
        end
    end
`else
    assign lng = 1'b0;
`endif

endmodule

module btn_conditioner #(
    parameter int N_BTN        = 5,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int LONG_CYC     = 300000000,
    parameter int CNT_W        = 29
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long
);

    if (DEBOUNCE_CYC < 2 || LONG_CYC <= DEBOUNCE_CYC ||
        CNT_W < $clog2(LONG_CYC) || CNT_W < $clog2(DEBOUNCE_CYC)) begin : g_cfg_err
        $error("btn_conditioner: inconsistent DEBOUNCE_CYC/LONG_CYC/CNT_W");
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC),
`ifdef BTN_CONDITIONER_LONG_PRESS_EN
            .LONG_CYC    (LONG_CYC),
`endif
            .CNT_W       (CNT_W)
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .raw  (btn_raw[i]),
            .level(btn_level[i]),
            .press(btn_press[i]),
            .rel  (btn_release[i]),
            .lng  (btn_long[i])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: per-cycle vector table plus a hand-written reset-mid-hold sequence.
// Long-press expectations follow BTN_CONDITIONER_LONG_PRESS_EN.

module tb_btn_conditioner;

    localparam int N_BTN = 5;
    localparam int DEB   = 4;
    localparam int LNG   = 12;

`ifdef BTN_CONDITIONER_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N_BTN-1:0] btn_raw = '0;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_long;

    btn_conditioner #(
        .N_BTN       (N_BTN),
        .DEBOUNCE_CYC(DEB),
        .LONG_CYC    (LNG),
        .CNT_W       (29)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_long   (btn_long)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] raw;
        logic       rst;
        logic [4:0] lvl;
        logic [4:0] prs;
        logic [4:0] rel;
        logic [4:0] lng;
        string      name;
    } vec_t;

    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;

    task automatic add(input int n, input string name, input logic r, input logic [4:0] raw,
                       input logic [4:0] lvl, input logic [4:0] prs, input logic [4:0] rel,
                       input logic [4:0] lng);
        vec_t v;
        v.raw = raw; v.rst = r; v.lvl = lvl; v.prs = prs; v.rel = rel; v.lng = lng; v.name = name;
        repeat (n) tbl.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [19:0] exp);
        logic [19:0] act;
        act = {btn_level, btn_press, btn_release, btn_long};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got lvl=%b prs=%b rel=%b lng=%b want lvl=%b prs=%b rel=%b lng=%b",
                     name, idx, act[19:15], act[14:10], act[9:5], act[4:0],
                     exp[19:15], exp[14:10], exp[9:5], exp[4:0]);
        end
    endtask

    // Drive one row, let one edge pass, compare 1 time unit after it.
    task automatic apply(input vec_t v, input int idx);
        logic [4:0] lng_exp;
        btn_raw = v.raw;
        rst     = v.rst;
        @(posedge clk);
        #1;
        lng_exp = LONG_EN ? v.lng : 5'b0;
        check(v.name, idx, {v.lvl, v.prs, v.rel, lng_exp});
    endtask

    task automatic step(input string name, input logic r, input logic [4:0] raw,
                        input logic [4:0] lvl, input logic [4:0] prs, input logic [4:0] rel,
                        input logic [4:0] lng);
        vec_t v;
        v.raw = raw; v.rst = r; v.lvl = lvl; v.prs = prs; v.rel = rel; v.lng = lng; v.name = name;
        apply(v, 0);
    endtask

    initial begin
        #1 rst = 1'b0;

        add(2, "reset", 1'b0, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0);
        add(2, "idle",  1'b1, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0);

        // Clean press/release on ch0; press visible after the 7th edge.
        add(6, "t1_wait",     1'b1, 5'b00001, 5'b0,     5'b0,     5'b0,     5'b0);
        add(1, "t1_press",    1'b1, 5'b00001, 5'b00001, 5'b00001, 5'b0,     5'b0);
        add(3, "t1_held",     1'b1, 5'b00001, 5'b00001, 5'b0,     5'b0,     5'b0);
        add(6, "t1_rel_wait", 1'b1, 5'b0,     5'b00001, 5'b0,     5'b0,     5'b0);
        add(1, "t1_release",  1'b1, 5'b0,     5'b0,     5'b0,     5'b00001, 5'b0);
        add(3, "t1_idle",     1'b1, 5'b0,     5'b0,     5'b0,     5'b0,     5'b0);

        // 3-cycle glitch on ch2 is rejected.
        add(3, "t2_glitch", 1'b1, 5'b00100, 5'b0, 5'b0, 5'b0, 5'b0);
        add(8, "t2_quiet",  1'b1, 5'b0,     5'b0, 5'b0, 5'b0, 5'b0);

        // Bouncy release on ch4: low 2, high 1, then low.
        add(6, "t3_wait",     1'b1, 5'b10000, 5'b0,     5'b0,     5'b0,     5'b0);
        add(1, "t3_press",    1'b1, 5'b10000, 5'b10000, 5'b10000, 5'b0,     5'b0);
        add(2, "t3_drop",     1'b1, 5'b0,     5'b10000, 5'b0,     5'b0,     5'b0);
        add(1, "t3_bounce",   1'b1, 5'b10000, 5'b10000, 5'b0,     5'b0,     5'b0);
        add(6, "t3_rel_wait", 1'b1, 5'b0,     5'b10000, 5'b0,     5'b0,     5'b0);
        add(1, "t3_release",  1'b1, 5'b0,     5'b0,     5'b0,     5'b10000, 5'b0);
        add(3, "t3_idle",     1'b1, 5'b0,     5'b0,     5'b0,     5'b0,     5'b0);

        // Long press on ch1: one pulse 11 edges after HELD, none while saturated.
        add(6,  "t4_wait",     1'b1, 5'b00010, 5'b0,     5'b0,     5'b0,     5'b0);
        add(1,  "t4_press",    1'b1, 5'b00010, 5'b00010, 5'b00010, 5'b0,     5'b0);
        add(10, "t4_held",     1'b1, 5'b00010, 5'b00010, 5'b0,     5'b0,     5'b0);
        add(1,  "t4_long",     1'b1, 5'b00010, 5'b00010, 5'b0,     5'b0,     5'b00010);
        add(12, "t4_sat",      1'b1, 5'b00010, 5'b00010, 5'b0,     5'b0,     5'b0);
        add(6,  "t4_rel_wait", 1'b1, 5'b0,     5'b00010, 5'b0,     5'b0,     5'b0);
        add(1,  "t4_release",  1'b1, 5'b0,     5'b0,     5'b0,     5'b00010, 5'b0);
        add(2,  "t4_idle",     1'b1, 5'b0,     5'b0,     5'b0,     5'b0,     5'b0);

        // Simultaneous presses on ch0, ch2, ch4.
        add(6, "t5_wait",     1'b1, 5'b10101, 5'b0,     5'b0,     5'b0,     5'b0);
        add(1, "t5_press",    1'b1, 5'b10101, 5'b10101, 5'b10101, 5'b0,     5'b0);
        add(1, "t5_held",     1'b1, 5'b10101, 5'b10101, 5'b0,     5'b0,     5'b0);
        add(6, "t5_rel_wait", 1'b1, 5'b0,     5'b10101, 5'b0,     5'b0,     5'b0);
        add(1, "t5_release",  1'b1, 5'b0,     5'b0,     5'b0,     5'b10101, 5'b0);
        add(2, "t5_idle",     1'b1, 5'b0,     5'b0,     5'b0,     5'b0,     5'b0);

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // Reset while ch3 is held; it must re-debounce and press again after reset.
        repeat (6) step("t6_wait", 1'b1, 5'b01000, 5'b0, 5'b0, 5'b0, 5'b0);
        step("t6_press", 1'b1, 5'b01000, 5'b01000, 5'b01000, 5'b0, 5'b0);
        repeat (2) step("t6_held", 1'b1, 5'b01000, 5'b01000, 5'b0, 5'b0, 5'b0);
        rst = 1'b0;
        #1;
        check("t6_async_rst", 0, 20'b0);
        repeat (2) step("t6_in_rst", 1'b0, 5'b01000, 5'b0, 5'b0, 5'b0, 5'b0);
        repeat (6) step("t6_rearm", 1'b1, 5'b01000, 5'b0, 5'b0, 5'b0, 5'b0);
        step("t6_fresh_press", 1'b1, 5'b01000, 5'b01000, 5'b01000, 5'b0, 5'b0);
        repeat (2) step("t6_held2", 1'b1, 5'b01000, 5'b01000, 5'b0, 5'b0, 5'b0);
        repeat (6) step("t6_rel_wait", 1'b1, 5'b0, 5'b01000, 5'b0, 5'b0, 5'b0);
        step("t6_release", 1'b1, 5'b0, 5'b0, 5'b0, 5'b01000, 5'b0);
        repeat (2) step("t6_idle", 1'b1, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
